// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a final cycle, MTHI/MTLO writes when not busy.
module mips_cpu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clock_enable,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state_q;
  logic [5:0]          cnt_q;
  logic                is_div_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     rem_q;
  logic [XLEN-1:0]     hi_q;
  logic [XLEN-1:0]     lo_q;
  logic                busy_q;
  logic                done_q;
  logic                dbz_q;

  logic                signed_op;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   acc_mul_d;
  logic [XLEN:0]       rem_shift;
  logic [XLEN:0]       rem_trial;
  logic                q_bit;
  logic [XLEN-1:0]     rem_d;
  logic [XLEN-1:0]     quot_d;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix;
  logic [XLEN-1:0]     rem_fix;

  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && op_a[XLEN-1]) ? (~op_a + 1'b1) : op_a;
    mag_b     = (signed_op && op_b[XLEN-1]) ? (~op_b + 1'b1) : op_b;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    acc_mul_d = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: 33-bit trial subtraction; borrow out means the quotient bit is 0.
    rem_shift = {rem_q, acc_q[XLEN-1]};
    rem_trial = rem_shift - {1'b0, opnd_q};
    q_bit     = ~rem_trial[XLEN];
    rem_d     = q_bit ? rem_trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    quot_d    = {acc_q[XLEN-2:0], q_bit};

    prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (clock_enable) begin
      if (!reset) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        is_div_q  <= 1'b0;
        neg_res_q <= 1'b0;
        neg_rem_q <= 1'b0;
        opnd_q    <= '0;
        acc_q     <= '0;
        rem_q     <= '0;
        hi_q      <= '0;
        lo_q      <= '0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        dbz_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (start) begin
              is_div_q  <= op[1];
              neg_res_q <= signed_op & (op_a[XLEN-1] ^ op_b[XLEN-1]);
              neg_rem_q <= signed_op & op_a[XLEN-1];
              opnd_q    <= op[1] ? mag_b : mag_a;
              acc_q     <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
              rem_q     <= '0;
              cnt_q     <= '0;
              if (op[1] && (op_b == '0)) begin
                hi_q    <= op_a;
                lo_q    <= '1;
                state_q <= S_DONE;
                done_q  <= 1'b1;
                dbz_q   <= 1'b1;
              end else begin
                state_q <= S_CALC;
                busy_q  <= 1'b1;
              end
            end else begin
              if (hi_we) hi_q <= wdata;
              if (lo_we) lo_q <= wdata;
              state_q <= S_IDLE;
            end
          end
          S_CALC: begin
            if (is_div_q) begin
              acc_q <= {acc_q[2*XLEN-1:XLEN], quot_d};
              rem_q <= rem_d;
            end else begin
              acc_q <= acc_mul_d;
            end
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_q <= S_FIX;
          end
          S_FIX: begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*XLEN-1:XLEN];
              lo_q <= prod_fix[XLEN-1:0];
            end
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed scenarios plus randomized
// operations compared against a plain-arithmetic model of HI/LO results.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clock_enable = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mips_cpu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .clock_enable(clock_enable), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // {hi, lo} from ordinary 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint q, r;
    longint unsigned uq, ur;
    logic [63:0] res;
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = ua * ub;
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb; r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub; ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Called at a negedge; start is seen by the next posedge (E0), returns at the negedge after E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b done=%b dbz=%b expected 0", busy, done, div_by_zero); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_tests++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_midcalc: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo); end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL reset_abort: got %0d active cycles expected 0", pulses); end
    $display("[TB] reset: mid-CALC abort checked");
  endtask

  task automatic test_mult_div();
    logic [1:0]  t_op [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] t_a  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] t_b  [5] = '{32'd3, 32'd3, 32'd2, 32'd7, 32'hFFFFFFFF};
    logic [31:0] t_hi [5] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'd2, 32'h0};
    logic [31:0] t_lo [5] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'd14, 32'h80000000};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL op%0d_busy: got %b expected 1", i, busy); end
      wait_done(cyc);
      $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", t_op[i], t_a[i], t_b[i], hi, lo, cyc);
      n_tests++; if (cyc !== 34) begin n_fail++; $display("FAIL op%0d_latency: got %0d expected 34", i, cyc); end
      n_tests++; if (hi !== t_hi[i] || lo !== t_lo[i]) begin n_fail++; $display("FAIL op%0d_result: got hi=%h lo=%h expected hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]); end
      n_tests++; if (div_by_zero !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL op%0d_flags: got dbz=%b busy=%b expected 0/0", i, div_by_zero, busy); end
      @(negedge clk);
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL op%0d_pulse: got done=%b expected 0", i, done); end
    end
  endtask

  task automatic test_div_zero();
    issue(2'd3, 32'h00001234, 32'h0);
    $display("[TB] DIVU 00001234/0 -> hi=%h lo=%h dbz=%b", hi, lo, div_by_zero);
    n_tests++; if (done !== 1'b1 || div_by_zero !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL dbz_flags: got done=%b dbz=%b busy=%b expected 1/1/0", done, div_by_zero, busy); end
    n_tests++; if (hi !== 32'h00001234 || lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbz_result: got hi=%h lo=%h expected 00001234/ffffffff", hi, lo); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dbz_clear: got done=%b dbz=%b busy=%b expected 0/0/0", done, div_by_zero, busy); end
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    hi_we = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    hi_we = 1'b0;
    n_tests++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mthi: got %h expected aaaa5555", hi); end
    lo_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    lo_we = 1'b0;
    n_tests++; if (lo !== 32'h12345678 || hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mtlo: got hi=%h lo=%h expected aaaa5555/12345678", hi, lo); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F0F0F;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    n_tests++; if (hi !== 32'h0F0F0F0F || lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL mt_both: got hi=%h lo=%h expected 0f0f0f0f", hi, lo); end
    issue(2'd1, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    lo_we = 1'b0;
    n_tests++; if (lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL mtlo_busy: got %h expected 0f0f0f0f", lo); end
    wait_done(cyc);
    n_tests++; if (hi !== 32'h0 || lo !== 32'd15) begin n_fail++; $display("FAIL mt_mult: got hi=%h lo=%h expected 0/0000000f", hi, lo); end
    lo_we = 1'b1; wdata = 32'hCAFEF00D;
    issue(2'd1, 32'd7, 32'd6);
    lo_we = 1'b0;
    n_tests++; if (lo !== 32'd15) begin n_fail++; $display("FAIL mtlo_start: got %h expected 0000000f", lo); end
    wait_done(cyc);
    $display("[TB] MULTU 7*6 with lo_we at start -> hi=%h lo=%h", hi, lo);
    n_tests++; if (lo !== 32'd42 || cyc !== 34) begin n_fail++; $display("FAIL start_wins: got lo=%h cycles=%0d expected 0000002a/34", lo, cyc); end
    @(negedge clk);
  endtask

  task automatic test_clock_enable();
    int cyc;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h13572468;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h11111111; clock_enable = 1'b0;
    @(negedge clk);
    hi_we = 1'b0; clock_enable = 1'b1;
    n_tests++; if (hi !== 32'h13572468) begin n_fail++; $display("FAIL ce_hold_idle: got %h expected 13572468", hi); end
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 10) clock_enable = 1'b0;
      if (cyc == 15) clock_enable = 1'b1;
      if (cyc == 12) begin
        n_tests++; if (busy !== 1'b1 || lo !== 32'h13572468) begin n_fail++; $display("FAIL ce_stall: got busy=%b lo=%h expected 1/13572468", busy, lo); end
      end
      @(negedge clk);
      cyc++;
    end
    clock_enable = 1'b1;
    $display("[TB] MULTU ffffffff*ffffffff with 5 stall cycles -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    n_tests++; if (cyc !== 39) begin n_fail++; $display("FAIL ce_latency: got %0d expected 39", cyc); end
    n_tests++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin n_fail++; $display("FAIL ce_result: got hi=%h lo=%h expected fffffffe/00000001", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(2'd0, 32'hFFFFFFFE, 32'd3);
    wait_done(cyc);
    n_tests++; if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL b2b_first: got done=%b hi=%h lo=%h expected 1/ffffffff/fffffffa", done, hi, lo); end
    issue(2'd3, 32'd100, 32'd7);
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_handoff: got busy=%b done=%b expected 1/0", busy, done); end
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin start = 1'b1; op = 2'd1; op_a = 32'd9; op_b = 32'd9; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    $display("[TB] DIVU 100/7 back-to-back with ignored start -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    n_tests++; if (cyc !== 34 || hi !== 32'd2 || lo !== 32'd14) begin n_fail++; $display("FAIL b2b_ignore_start: got cycles=%0d hi=%h lo=%h expected 34/2/e", cyc, hi, lo); end
    issue(2'd2, 32'd5, 32'd0);
    n_tests++; if (done !== 1'b1 || div_by_zero !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_dbz: got done=%b dbz=%b hi=%h lo=%h expected 1/1/5/ffffffff", done, div_by_zero, hi, lo); end
    issue(2'd0, 32'hFFFFFFFE, 32'd3);
    n_tests++; if (div_by_zero !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_dbz_clear: got dbz=%b busy=%b done=%b expected 0/1/0", div_by_zero, busy, done); end
    wait_done(cyc);
    n_tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL b2b_last: got hi=%h lo=%h expected ffffffff/fffffffa", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp_r;
    logic        exp_dbz;
    int          exp_cyc, cyc;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
      if (o[1] && $urandom_range(0, 4) == 0) b = 32'd0;
      if (i == 0) begin o = 2'd2; a = 32'h80000000; b = 32'hFFFFFFFF; end
      exp_r   = ref_model(o, a, b);
      exp_dbz = o[1] && (b == 32'd0);
      exp_cyc = exp_dbz ? 1 : 34;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(o, a, b);
      wait_done(cyc);
      $display("[TB] rand%0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b cycles=%0d", i, o, a, b, hi, lo, div_by_zero, cyc);
      n_tests++; if ({hi, lo} !== exp_r) begin n_fail++; $display("FAIL rand%0d_result: got %h_%h expected %h_%h", i, hi, lo, exp_r[63:32], exp_r[31:0]); end
      n_tests++; if (div_by_zero !== exp_dbz || cyc !== exp_cyc) begin n_fail++; $display("FAIL rand%0d_timing: got dbz=%b cycles=%0d expected %b/%0d", i, div_by_zero, cyc, exp_dbz, exp_cyc); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult_div();
    test_div_zero();
    test_mthi_mtlo();
    test_clock_enable();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
